// File: rtl/conv_window_buffer.sv
// conv_window_buffer: 3x3 sliding window over a raster pixel stream.
// Two line buffers feed a 3x3 shift window; one registered output stage.
module conv_window_buffer #(
  parameter int DATA_W = 17,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_pixel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [9*DATA_W-1:0] out_win,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // lb0 holds row r-1, lb1 holds row r-2, indexed by column
  logic [DATA_W-1:0]   lb0_q [IMG_W];
  logic [DATA_W-1:0]   lb1_q [IMG_W];
  logic [DATA_W-1:0]   win_q [3][3];

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic                ov_q, ov_d;
  logic                ol_q, ol_d;
  logic [9*DATA_W-1:0] ow_q, ow_d;

  logic                accept;
  logic                complete;
  logic                frame_end;
  logic [DATA_W-1:0]   top;
  logic [DATA_W-1:0]   mid;

  assign in_ready  = ~ov_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign top       = lb1_q[col_q];
  assign mid       = lb0_q[col_q];
  assign complete  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign frame_end = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));

  assign out_win   = ow_q;
  assign out_valid = ov_q;
  assign out_last  = ol_q;

  // next-state: raster counters, output stage load/drain
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ov_d  = ov_q;
    ol_d  = ol_q;
    ow_d  = ow_q;
    if (accept) begin
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_H-1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (complete) begin
      ov_d = 1'b1;
      ol_d = frame_end;
      for (int r = 0; r < 3; r++) begin
        ow_d[DATA_W*(3*r)   +: DATA_W] = win_q[r][1];
        ow_d[DATA_W*(3*r+1) +: DATA_W] = win_q[r][2];
      end
      ow_d[DATA_W*2 +: DATA_W] = top;
      ow_d[DATA_W*5 +: DATA_W] = mid;
      ow_d[DATA_W*8 +: DATA_W] = in_pixel;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  // control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      ov_q  <= 1'b0;
      ol_q  <= 1'b0;
      ow_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ov_q  <= ov_d;
      ol_q  <= ol_d;
      ow_q  <= ow_d;
    end
  end

  // line buffers and window shift on every accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= mid;
      lb0_q[col_q] <= in_pixel;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= top;
      win_q[1][2] <= mid;
      win_q[2][2] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: vector table, directed sequences and a
// randomized 8x8 run checked against a frame-array window model.
module tb_conv_window_buffer;

  localparam int DW = 17;
  localparam int WB = 9*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst4 = 1'b1, iv4 = 1'b0, or4 = 1'b1;
  logic [DW-1:0] px4 = '0;
  logic          ir4, ov4, ol4;
  logic [WB-1:0] win4;

  logic          rst8 = 1'b1, iv8 = 1'b0, or8 = 1'b1;
  logic [DW-1:0] px8 = '0;
  logic          ir8, ov8, ol8;
  logic [WB-1:0] win8;

  conv_window_buffer #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst4), .in_pixel(px4), .in_valid(iv4),
    .in_ready(ir4), .out_win(win4), .out_valid(ov4),
    .out_ready(or4), .out_last(ol4)
  );

  conv_window_buffer #(.DATA_W(DW), .IMG_W(8), .IMG_H(8)) u8 (
    .clk(clk), .rst(rst8), .in_pixel(px8), .in_valid(iv8),
    .in_ready(ir8), .out_win(win8), .out_valid(ov8),
    .out_ready(or8), .out_last(ol8)
  );

  int tot = 0;
  int bad = 0;

  logic [DW-1:0] img4 [4][4];
  logic [DW-1:0] img8 [8][8];
  int r4 = 0, c4 = 0, r8 = 0, c8 = 0;
  logic [WB-1:0] q4 [$];
  logic          ql4 [$];
  logic [WB-1:0] q8 [$];
  logic          ql8 [$];
  logic [WB-1:0] obs4 [$];
  logic          obl4 [$];
  int n8 = 0;

  task automatic chk(input string nm, input logic [WB-1:0] got,
                     input logic [WB-1:0] want);
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // window of a 4x4 frame whose pixel (r,c) is off + 4r + c + 1
  function automatic logic [WB-1:0] w4x4(input int off, input int r,
                                         input int c);
    logic [WB-1:0] w;
    for (int k = 0; k < 9; k++)
      w[DW*k +: DW] = DW'(off + 4*(r-2+k/3) + (c-2+k%3) + 1);
    return w;
  endfunction

  // reference model: store accepted pixels in a frame array, emit windows
  always @(negedge clk) begin : mon
    logic [WB-1:0] e;
    logic          l;
    if (rst4) begin
      r4 = 0; c4 = 0; q4.delete(); ql4.delete();
    end else begin
      if (ov4 && or4) begin
        obs4.push_back(win4);
        obl4.push_back(ol4);
        tot++;
        if (q4.size() == 0) begin
          bad++;
          $display("FAIL u4_extra_window got=%h", win4);
        end else begin
          e = q4.pop_front();
          l = ql4.pop_front();
          if (e !== win4 || l !== ol4) begin
            bad++;
            $display("FAIL u4_window got=%h/%b want=%h/%b", win4, ol4, e, l);
          end
        end
      end
      if (iv4 && ir4) begin
        img4[r4][c4] = px4;
        if (r4 >= 2 && c4 >= 2) begin
          for (int k = 0; k < 9; k++)
            e[DW*k +: DW] = img4[r4-2+k/3][c4-2+k%3];
          q4.push_back(e);
          ql4.push_back(r4 == 3 && c4 == 3);
        end
        c4++;
        if (c4 == 4) begin c4 = 0; r4 = (r4 == 3) ? 0 : r4 + 1; end
      end
    end
    if (rst8) begin
      r8 = 0; c8 = 0; q8.delete(); ql8.delete();
    end else begin
      if (ov8 && or8) begin
        n8++;
        tot++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL u8_extra_window got=%h", win8);
        end else begin
          e = q8.pop_front();
          l = ql8.pop_front();
          if (e !== win8 || l !== ol8) begin
            bad++;
            $display("FAIL u8_window got=%h/%b want=%h/%b", win8, ol8, e, l);
          end
        end
      end
      if (iv8 && ir8) begin
        img8[r8][c8] = px8;
        if (r8 >= 2 && c8 >= 2) begin
          for (int k = 0; k < 9; k++)
            e[DW*k +: DW] = img8[r8-2+k/3][c8-2+k%3];
          q8.push_back(e);
          ql8.push_back(r8 == 7 && c8 == 7);
        end
        c8++;
        if (c8 == 8) begin c8 = 0; r8 = (r8 == 7) ? 0 : r8 + 1; end
      end
    end
  end

  task automatic send4(input logic [DW-1:0] p);
    int t = 0;
    iv4 = 1'b1; px4 = p;
    forever begin
      @(negedge clk);
      if (ir4) break;
      t++;
      if (t > 200) begin
        tot++; bad++;
        $display("FAIL u4_accept_timeout pixel=%0d", p);
        break;
      end
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic send8(input logic [DW-1:0] p);
    int t = 0;
    iv8 = 1'b1; px8 = p;
    forever begin
      @(negedge clk);
      if (ir8) break;
      t++;
      if (t > 200) begin
        tot++; bad++;
        $display("FAIL u8_accept_timeout pixel=%0d", p);
        break;
      end
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic reset4();
    rst4 = 1'b1; iv4 = 1'b0;
    @(posedge clk); #1;
    rst4 = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] px;
    logic          ordy;
    logic          eir;
    logic          eov;
    logic          eol;
    logic [DW-1:0] e0;
    logic [DW-1:0] e8;
  } vec_t;

  vec_t tv [18];

  initial begin : main
    logic [WB-1:0] held;
    bit done8;
    int t;

    for (int i = 0; i < 18; i++) begin
      tv[i].iv   = (i < 16);
      tv[i].px   = (i < 16) ? DW'(i + 1) : '0;
      tv[i].ordy = 1'b1;
      tv[i].eir  = 1'b1;
      tv[i].eov  = 1'b0;
      tv[i].eol  = 1'b0;
      tv[i].e0   = '0;
      tv[i].e8   = '0;
    end
    tv[11].eov = 1'b1; tv[11].e0 = 1; tv[11].e8 = 11;
    tv[12].eov = 1'b1; tv[12].e0 = 2; tv[12].e8 = 12;
    tv[15].eov = 1'b1; tv[15].e0 = 5; tv[15].e8 = 15;
    tv[16].eov = 1'b1; tv[16].e0 = 6; tv[16].e8 = 16;
    tv[16].eol = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst4_out_valid", WB'(ov4), '0);
    chk("rst4_out_last", WB'(ol4), '0);
    chk("rst4_out_win", win4, '0);
    chk("rst4_in_ready", WB'(ir4), WB'(1));
    chk("rst8_out_valid", WB'(ov8), '0);
    chk("rst8_out_win", win8, '0);
    chk("rst8_in_ready", WB'(ir8), WB'(1));
    @(posedge clk); #1;
    rst4 = 1'b0;

    obs4.delete(); obl4.delete();
    for (int i = 0; i < 18; i++) begin
      iv4 = tv[i].iv; px4 = tv[i].px; or4 = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), WB'(ir4), WB'(tv[i].eir));
      chk($sformatf("tbl%0d_out_valid", i), WB'(ov4), WB'(tv[i].eov));
      if (tv[i].eov) begin
        chk($sformatf("tbl%0d_last", i), WB'(ol4), WB'(tv[i].eol));
        chk($sformatf("tbl%0d_e0", i), WB'(win4[0 +: DW]), WB'(tv[i].e0));
        chk($sformatf("tbl%0d_e8", i), WB'(win4[8*DW +: DW]), WB'(tv[i].e8));
      end
      @(posedge clk); #1;
    end
    chk("tbl_count", WB'(obs4.size()), WB'(4));
    chk("tbl_first", obs4[0], w4x4(0, 2, 2));
    chk("tbl_final", obs4[3], w4x4(0, 3, 3));

    reset4();
    obs4.delete(); obl4.delete();
    or4 = 1'b0;
    fork
      begin
        for (int p = 1; p <= 16; p++) send4(DW'(p));
      end
      begin
        t = 0;
        while (!ov4 && t < 100) begin @(negedge clk); t++; end
        chk("stall_seen", WB'(ov4), WB'(1));
        held = win4;
        chk("stall_first", held, w4x4(0, 2, 2));
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk($sformatf("stall%0d_in_ready", k), WB'(ir4), '0);
          chk($sformatf("stall%0d_valid", k), WB'(ov4), WB'(1));
          chk($sformatf("stall%0d_win", k), win4, held);
        end
        @(posedge clk); #1;
        or4 = 1'b1;
      end
    join
    drain();
    chk("stall_count", WB'(obs4.size()), WB'(4));
    chk("stall_w1", obs4[1], w4x4(0, 2, 3));
    chk("stall_w3", obs4[3], w4x4(0, 3, 3));

    reset4();
    obs4.delete(); obl4.delete();
    for (int p = 1; p <= 16; p++) send4(DW'(p));
    for (int p = 101; p <= 116; p++) send4(DW'(p));
    drain();
    chk("two_count", WB'(obs4.size()), WB'(8));
    chk("two_w5", obs4[4], w4x4(100, 2, 2));
    for (int i = 0; i < 8; i++)
      chk($sformatf("two_last%0d", i), WB'(obl4[i]),
          WB'(i == 3 || i == 7));

    reset4();
    obs4.delete(); obl4.delete();
    for (int p = 1; p <= 7; p++) send4(DW'(p));
    reset4();
    for (int p = 1; p <= 10; p++) send4(DW'(p));
    chk("mid_rst_early", WB'(obs4.size()), '0);
    for (int p = 11; p <= 16; p++) send4(DW'(p));
    drain();
    chk("mid_rst_count", WB'(obs4.size()), WB'(4));
    chk("mid_rst_first", obs4[0], w4x4(0, 2, 2));

    reset4();
    obs4.delete(); obl4.delete();
    for (int p = 0; p < 16; p++) send4(17'h1FFFF);
    drain();
    chk("ones_count", WB'(obs4.size()), WB'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("ones_w%0d", i), obs4[i], {WB{1'b1}});

    rst8 = 1'b0;
    done8 = 1'b0;
    fork
      begin
        for (int p = 0; p < 128; p++) begin
          while ($urandom_range(0, 2) == 0) begin
            iv8 = 1'b0;
            @(posedge clk); #1;
          end
          send8(DW'($urandom));
        end
        done8 = 1'b1;
      end
      begin
        while (!done8) begin
          or8 = $urandom_range(0, 1) == 1;
          @(posedge clk); #1;
        end
        or8 = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("rand_count", WB'(n8), WB'(72));
    chk("rand_left", WB'(q8.size()), '0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 Parameter: DATA_W, 17, pixel width; matches the 17-bit data operand of the downstream 3x3 convolution unit.
REQ-002 Parameter: IMG_W, 8, image width in pixels; legal range 3 or greater.
REQ-003 Parameter: IMG_H, 8, image height in pixels; legal range 3 or greater.
REQ-004 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port: rst, input, 1, synchronous active-high reset.
REQ-006 Port: in_pixel, input, DATA_W, raster-order pixel (row-major, top-left first).
REQ-007 Port: in_valid, input, 1, in_pixel holds a valid pixel.
REQ-008 Port: in_ready, output, 1, block accepts a pixel this cycle.
REQ-009 Port: out_win, output, 9*DATA_W, 3x3 window; element k = 3*r + c occupies bits [DATA_W*k + DATA_W-1 : DATA_W*k].
REQ-010 Port: out_win indexing detail: r=0 is the top (oldest) row and c=0 is the left (oldest) column.
REQ-011 Port: out_valid, output, 1, out_win holds a valid window.
REQ-012 Port: out_ready, input, 1, downstream convolution stage consumes the window.
REQ-013 Port: out_last, output, 1, qualified by out_valid; marks the final window of a frame.

Function
REQ-014 The block SHALL transfer an input pixel only when in_valid and in_ready are both 1 in the same cycle (input handshake).
REQ-015 The block SHALL transfer an output window only when out_valid and out_ready are both 1 in the same cycle (output handshake).
REQ-016 The block SHALL keep two line buffers of IMG_W entries each plus a 3x3 register window, and SHALL shift them only on an input handshake.
REQ-017 The block SHALL track column (0..IMG_W-1) and row (0..IMG_H-1) counters, both advanced only on an input handshake.
REQ-018 Column SHALL wrap to 0 after IMG_W-1 and increment row; after pixel (IMG_H-1, IMG_W-1), both counters SHALL wrap to 0.
REQ-019 A window SHALL be produced only for an accepted pixel with row >= 2 and col >= 2 (valid convolution, no padding).
REQ-020 Each frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-021 The window produced by pixel (r, c) SHALL contain pixels at rows r-2..r and columns c-2..c, with element 8 equal to pixel (r, c).
REQ-022 Latency: out_valid SHALL rise in the cycle after the completing input handshake; out_win/out_last are registered.
REQ-023 in_ready SHALL equal (not out_valid) or out_ready, as a single output register stage.
REQ-024 Throughput SHALL be one pixel per cycle with no bubbles when in_valid=1 and out_ready=1.
REQ-025 When out_valid=1 and out_ready=0: out_win, out_last and out_valid SHALL hold stable, and no input SHALL be accepted.
REQ-026 Simultaneous output handshake and window-completing input handshake: the new window SHALL load and out_valid SHALL stay 1.
REQ-027 Output handshake with no new window completing: out_valid SHALL drop to 0 in the next cycle.
REQ-028 An accepted pixel that does not complete a window SHALL still update the buffers and counters.
REQ-029 out_last SHALL be 1 only with the window from pixel (IMG_H-1, IMG_W-1).
REQ-030 in_valid gaps SHALL not alter state, and windows SHALL be identical to gapless input.
REQ-031 A new frame SHALL begin immediately after the last pixel, and no window SHALL mix pixels of two frames.

Reset
REQ-032 While rst=1, the block SHALL set row and column counters to 0, out_valid=0, out_last=0 and out_win=0; in_ready SHALL then be 1.
REQ-033 Line buffer and window register contents SHALL not require reset; no window SHALL be emitted before rows 0-2 are refilled.
REQ-034 Reset asserted mid-frame SHALL discard any pending window, and the next accepted pixel SHALL be treated as (0,0).

Verification
REQ-035 IMG_W=IMG_H=4, pixels 1..16, out_ready=1 -> exactly 4 windows; first = {1,2,3,5,6,7,9,10,11}; last = {6,7,8,10,11,12,14,15,16} with out_last=1.
REQ-036 Same stimulus, out_ready held 0 for 5 cycles at the first window -> window held stable, in_ready=0, no pixel lost; window sequence unchanged.
REQ-037 Two back-to-back 4x4 frames (1..16 then 101..116) -> 8 windows; 5th window = {101,102,103,105,106,107,109,110,111}; out_last on windows 4 and 8 only.
REQ-038 rst pulsed after pixel 7, then pixels 1..16 -> first window = {1,2,3,5,6,7,9,10,11}; no window emitted before the post-reset pixel 11.
REQ-039 Random in_valid gaps and random out_ready on an 8x8 frame -> 36 windows matching a reference model, each exactly once.
REQ-040 Pixel value 2^17-1 at all positions -> every out_win element = 0x1FFFF, with no truncation.
